// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the RV64 M-extension.
// Covers div/divu/rem/remu and their 32-bit W variants, with RISC-V special-case results.
module div_unit #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op_signed,
    input  logic            op_word,
    input  logic            op_rem,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned HALF = XLEN / 2;
    localparam logic [CNT_W-1:0] LAST_D = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] LAST_W = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              neg_q_q, neg_q_d;
    logic              neg_r_q, neg_r_d;
    logic              sel_rem_q, sel_rem_d;
    logic              word_q, word_d;

    // Word results are always sign-extended from bit 31, even for unsigned ops.
    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] v, input logic word);
        return word ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_res;
    logic            sign_a, sign_b, div_zero, ovf, accept;

    always_comb begin
        if (op_word) begin
            a_ext = op_signed ? {{HALF{src1[HALF-1]}}, src1[HALF-1:0]}
                              : {{HALF{1'b0}}, src1[HALF-1:0]};
            b_ext = op_signed ? {{HALF{src2[HALF-1]}}, src2[HALF-1:0]}
                              : {{HALF{1'b0}}, src2[HALF-1:0]};
            min_val = {{(HALF + 1){1'b1}}, {(HALF - 1){1'b0}}};
        end else begin
            a_ext   = src1;
            b_ext   = src2;
            min_val = {1'b1, {(XLEN - 1){1'b0}}};
        end
        sign_a   = op_signed & a_ext[XLEN-1];
        sign_b   = op_signed & b_ext[XLEN-1];
        a_mag    = sign_a ? -a_ext : a_ext;
        b_mag    = sign_b ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        ovf      = op_signed & (a_ext == min_val) & (b_ext == '1);
        if (div_zero) begin
            spec_res = op_rem ? a_ext : '1;
        end else begin
            spec_res = op_rem ? '0 : a_ext;
        end
        accept = in_valid & in_ready & ~flush;
    end

    // One restoring step: the next dividend bit always enters from the top of quo_q.
    logic [XLEN:0]   rem_sh, diff;
    logic            qbit;
    logic [XLEN-1:0] rem_step, quo_step, q_fin, r_fin, calc_res;

    always_comb begin
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        diff     = rem_sh - {1'b0, dvs_q};
        qbit     = ~diff[XLEN];
        rem_step = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_step = {quo_q[XLEN-2:0], qbit};
        q_fin    = neg_q_q ? -quo_step : quo_step;
        r_fin    = neg_r_q ? -rem_step : rem_step;
        calc_res = fmt(sel_rem_q ? r_fin : q_fin, word_q);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        sel_rem_d = sel_rem_q;
        word_d    = word_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (div_zero || ovf) begin
                        state_d  = StDone;
                        result_d = fmt(spec_res, op_word);
                    end else begin
                        state_d   = StCalc;
                        cnt_d     = '0;
                        rem_d     = '0;
                        // Word dividends are left-aligned so the step logic is width-agnostic.
                        quo_d     = op_word ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
                        dvs_d     = b_mag;
                        neg_q_d   = sign_a ^ sign_b;
                        neg_r_d   = sign_a;
                        sel_rem_d = op_rem;
                        word_d    = op_word;
                    end
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == (word_q ? LAST_W : LAST_D)) begin
                        state_d  = StDone;
                        result_d = calc_res;
                    end
                end
            end
            StDone: begin
                if (flush || out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            sel_rem_q <= 1'b0;
            word_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            sel_rem_q <= sel_rem_d;
            word_q    <= word_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        result    = result_q;
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: arithmetic, special cases, latency,
// hold, flush and asynchronous reset behaviour.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op_signed;
    logic        op_word;
    logic        op_rem;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(.XLEN(64), .CNT_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_signed (op_signed),
        .op_word   (op_word),
        .op_rem    (op_rem),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Present an op for one edge, then scramble the inputs to prove they were latched.
    task automatic start_op(input logic s, input logic w, input logic r,
                            input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        op_signed = s;
        op_word   = w;
        op_rem    = r;
        src1      = a;
        src2      = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        op_signed = ~s;
        op_word   = ~w;
        op_rem    = ~r;
        src1      = 64'hA5A5_5A5A_0F0F_F0F0;
        src2      = 64'h3;
    endtask

    // Latency counts edges from the accept edge (inclusive) to the first out_valid sample.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic w, input logic r,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        start_op(s, w, r, a, b);
        wait_valid(lat);
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_eq(tag, result, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, " back to idle"}, {63'b0, in_ready}, 64'd1);
    endtask

    initial begin
        int lat;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_signed = 1'b0;
        op_word   = 1'b0;
        op_rem    = 1'b0;
        src1      = '0;
        src2      = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check_eq("reset in_ready", {63'b0, in_ready}, 64'd1);
        check_eq("reset out_valid", {63'b0, out_valid}, 64'd0);
        check_eq("reset busy", {63'b0, busy}, 64'd0);
        check_eq("reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        //     tag       sgn   word  rem   src1                    src2                    expected                lat
        run_op("divu",   1'b0, 1'b0, 1'b0, 64'd100,                64'd7,                  64'd14,                 65);
        run_op("remu",   1'b0, 1'b0, 1'b1, 64'd100,                64'd7,                  64'd2,                  65);
        run_op("div",    1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("rem",    1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("divu0",  1'b0, 1'b0, 1'b0, 64'h1234,               64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu0",  1'b0, 1'b0, 1'b1, 64'h1234,               64'd0,                  64'h1234,               1);
        run_op("divuw0", 1'b0, 1'b1, 1'b0, 64'h1234,               64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("divovf", 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        run_op("removf", 1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,               1);
        run_op("divwovf", 1'b1, 1'b1, 1'b0, 64'h8000_0000,         64'hFFFF_FFFF,          64'hFFFF_FFFF_8000_0000, 1);
        run_op("divuw",  1'b0, 1'b1, 1'b0, 64'hDEAD_BEEF_FFFF_FFFE, 64'd2,                 64'h0000_0000_7FFF_FFFF, 33);
        run_op("remw",   1'b1, 1'b1, 1'b1, 64'hFFFF_FFF9,          64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("divw",   1'b1, 1'b1, 1'b0, 64'hFFFF_FFF9,          64'd2,                  64'hFFFF_FFFF_FFFF_FFFD, 33);
        run_op("remuw",  1'b0, 1'b1, 1'b1, 64'hFFFF_FFF9,          64'd2,                  64'd1,                  33);
        run_op("divuw sx", 1'b0, 1'b1, 1'b0, 64'hFFFF_FFF0,        64'd1,                  64'hFFFF_FFFF_FFFF_FFF0, 33);

        // Result held while the consumer stalls.
        start_op(1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
        wait_valid(lat);
        check_eq("hold latency", 64'(lat), 64'd65);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold out_valid", {63'b0, out_valid}, 64'd1);
            check_eq("hold result", result, 64'd14);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("hold release", {63'b0, out_valid}, 64'd0);

        // Flush mid-CALC aborts without ever raising out_valid.
        start_op(1'b0, 1'b0, 1'b0, 64'd1000, 64'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush busy", {63'b0, busy}, 64'd0);
        check_eq("flush in_ready", {63'b0, in_ready}, 64'd1);
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_eq("flush no result", 64'(seen), 64'd0);

        // Flush together with in_valid in IDLE drops the request.
        @(negedge clk);
        src1     = 64'd9;
        src2     = 64'd3;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check_eq("idle flush drop", {63'b0, busy}, 64'd0);

        // Asynchronous reset in the middle of CALC.
        start_op(1'b0, 1'b0, 1'b0, 64'd500, 64'd7);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check_eq("pre-reset busy", {63'b0, busy}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async rst busy", {63'b0, busy}, 64'd0);
        check_eq("async rst in_ready", {63'b0, in_ready}, 64'd1);
        check_eq("async rst out_valid", {63'b0, out_valid}, 64'd0);
        check_eq("async rst result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("post-reset idle", {63'b0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
